muldiv_iter: RTL
================

MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; legal range 4..64.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; accepted only in IDLE.
REQ-005 flush  input  1  abort the current operation.
REQ-006 op  input  2  operation code: UMUL, SMUL, UDIV or SDIV.
REQ-007 a  input  WIDTH  multiplicand or dividend; sampled only on the accept edge.
REQ-008 b  input  WIDTH  multiplier or divisor; sampled only on the accept edge.
REQ-009 lo  output  WIDTH  product bits [WIDTH-1:0], or quotient.
REQ-010 hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH], or remainder.
REQ-011 busy  output  1  high in every state except IDLE and DONE.
REQ-012 done  output  1  one-cycle pulse: lo/hi/dz are valid.
REQ-013 dz  output  1  divide-by-zero flag for the last completed division.

Function
REQ-014 FSM states SHALL be IDLE, RUN, FIX and DONE.
REQ-015 IDLE, start=1, flush=0: latch op; load operands (absolute values for SMUL/SDIV); record result signs; load counter=WIDTH-1; go to RUN.
REQ-016 RUN SHALL do one radix-2 step per cycle for exactly WIDTH cycles, then go to FIX.
- Multiply: shift-add into a 2*WIDTH accumulator.
- Divide: restoring shift-subtract.
REQ-017 FIX SHALL apply the sign fix-up, register lo/hi/dz, and go to DONE.
REQ-018 DONE SHALL hold done=1 for one cycle, then go to IDLE; a start in DONE is ignored.
REQ-019 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH+1 (33 cycles for WIDTH=32), fixed for all ops and operands.
REQ-020 lo/hi/dz SHALL hold their values from the DONE cycle until the next FIX; they SHALL NOT change during RUN.
REQ-021 Signed multiply: the product SHALL be negated when exactly one operand is negative; full 2*WIDTH two's-complement result.
REQ-022 Signed divide: quotient SHALL truncate toward zero; the remainder SHALL take the dividend's sign.
REQ-023 Divisor zero: lo=0, hi=a, dz=1, same latency as any other operation; any other op SHALL give dz=0.
REQ-024 SDIV of the most-negative value by -1: lo=most-negative, hi=0, dz=0 (wrap, no trap).
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 flush=1 in RUN or FIX: next state IDLE, no done pulse, lo/hi/dz unchanged.
REQ-027 flush=1 in IDLE or DONE SHALL have no effect on state; flush and start together in IDLE SHALL leave the block in IDLE.
REQ-028 A change of op, a or b after the accept edge SHALL NOT affect the running operation.

Reset
REQ-029 reset=1 at any edge SHALL force state IDLE, counter=0, lo=0, hi=0, dz=0, done=0, busy=0; it takes priority over start and flush.
REQ-030 Reset during RUN SHALL discard the operation; no done pulse SHALL follow.

Structure
REQ-031 Package muldiv_pkg SHALL hold:
- op encoding: UMUL=2'b00, SMUL=2'b01, UDIV=2'b10, SDIV=2'b11;
- the FSM state enum;
- the helper function for the counter width, $clog2(WIDTH).
REQ-032 A single sub-module cond_neg SHALL be used.
- Parametrised width; conditional two's-complement negate.
- Instanced for operand absolute value and for result fix-up.
REQ-033 Implementation: one FSM process, one datapath register process; no combinational multiply or divide operators.

Verification (WIDTH=32)
REQ-034 UMUL a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001, done exactly 33 cycles after accept.
REQ-035 SMUL a=FFFFFFFD (-3), b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB; SDIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-036 UDIV a=00000064, b=0 -> lo=0, hi=00000064, dz=1; a following UDIV 100/7 -> lo=0000000E, hi=00000002, dz=0.
REQ-037 SDIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, dz=0.
REQ-038 Second start during RUN -> ignored, first result correct; flush at cycle 10 of RUN -> IDLE next cycle, no done pulse, lo/hi keep their prior values.
REQ-039 reset asserted mid-RUN -> all outputs 0 on the next cycle; a new start then completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// the op encoding, the FSM state type and the counter-width helper.
package muldiv_pkg;

  localparam logic [1:0] UMUL = 2'b00;
  localparam logic [1:0] SMUL = 2'b01;
  localparam logic [1:0] UDIV = 2'b10;
  localparam logic [1:0] SDIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between a requester (master) and the muldiv unit (slave).
interface muldiv_if #(parameter int WIDTH = 32);

  logic             start;
  logic             flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (
    output start, flush, op, a, b,
    input  lo, hi, busy, done, dz
  );

  modport slave (
    input  start, flush, op, a, b,
    output lo, hi, busy, done, dz
  );

endinterface

// File: rtl/muldiv_cond_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module cond_neg #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring), one bit per cycle.
//   state | meaning
//   IDLE  | waiting for start; results held
//   RUN   | WIDTH shift-add / shift-subtract steps on operand magnitudes
//   FIX   | sign fix-up, divide-by-zero override, results registered
//   DONE  | one-cycle done pulse
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  muldiv_if.slave   bus
);

  localparam int CW = cnt_w(WIDTH);

  state_e            state;
  logic [CW-1:0]     cnt;

  logic              div_q;
  logic              neg_lo;
  logic              neg_hi;
  logic              b_zero;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  p_hi;
  logic [WIDTH-1:0]  p_lo;
  logic [WIDTH-1:0]  a_raw;
  logic [WIDTH-1:0]  lo_q;
  logic [WIDTH-1:0]  hi_q;
  logic              dz_q;

  logic              accept;
  logic              sa;
  logic              sb;
  logic [WIDTH-1:0]  a_abs;
  logic [WIDTH-1:0]  b_abs;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH:0]    trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]  q_fix;
  logic [WIDTH-1:0]  r_fix;

  assign accept = (state == IDLE) && bus.start && !bus.flush;
  assign sa     = bus.op[0] & bus.a[WIDTH-1];
  assign sb     = bus.op[0] & bus.b[WIDTH-1];

  cond_neg #(.W(WIDTH)) u_abs_a (.neg(sa), .x(bus.a), .y(a_abs));
  cond_neg #(.W(WIDTH)) u_abs_b (.neg(sb), .x(bus.b), .y(b_abs));

  cond_neg #(.W(2*WIDTH)) u_fix_prod (.neg(neg_hi), .x({p_hi, p_lo}), .y(prod_fix));
  cond_neg #(.W(WIDTH))   u_fix_quo  (.neg(neg_lo), .x(p_lo), .y(q_fix));
  cond_neg #(.W(WIDTH))   u_fix_rem  (.neg(neg_hi), .x(p_hi), .y(r_fix));

  // Multiply: p_lo holds the shrinking multiplier; divide: p_lo holds the
  // dividend shifting out and the quotient shifting in, p_hi the remainder.
  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
  assign div_shift = {p_hi, p_lo[WIDTH-1]};
  assign trial     = div_shift - {1'b0, mcand};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start && !bus.flush) begin
          state <= RUN;
          cnt   <= CW'(WIDTH-1);
        end
        RUN: begin
          if (bus.flush)
            state <= IDLE;
          else if (cnt == '0)
            state <= FIX;
          else
            cnt <= cnt - CW'(1);
        end
        FIX:     state <= bus.flush ? IDLE : DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      b_zero <= 1'b0;
      mcand  <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      a_raw  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      dz_q   <= 1'b0;
    end else if (accept) begin
      div_q  <= bus.op[1];
      a_raw  <= bus.a;
      b_zero <= (bus.b == '0);
      p_hi   <= '0;
      neg_lo <= sa ^ sb;
      // Remainder follows the dividend; the product sign is the XOR.
      neg_hi <= bus.op[1] ? sa : (sa ^ sb);
      mcand  <= bus.op[1] ? b_abs : a_abs;
      p_lo   <= bus.op[1] ? a_abs : b_abs;
    end else if (state == RUN) begin
      if (div_q) begin
        if (!trial[WIDTH]) begin
          p_hi <= trial[WIDTH-1:0];
          p_lo <= {p_lo[WIDTH-2:0], 1'b1};
        end else begin
          p_hi <= div_shift[WIDTH-1:0];
          p_lo <= {p_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
      end
    end else if (state == FIX && !bus.flush) begin
      if (div_q && b_zero) begin
        lo_q <= '0;
        hi_q <= a_raw;
        dz_q <= 1'b1;
      end else if (div_q) begin
        lo_q <= q_fix;
        hi_q <= r_fix;
        dz_q <= 1'b0;
      end else begin
        {hi_q, lo_q} <= prod_fix;
        dz_q <= 1'b0;
      end
    end
  end

  assign bus.lo   = lo_q;
  assign bus.hi   = hi_q;
  assign bus.dz   = dz_q;
  assign bus.busy = (state == RUN) || (state == FIX);
  assign bus.done = (state == DONE);

endmodule
